// File: rtl/fm_dac_multi.sv
// Multi-channel distance-to-pitch synthesizer: each channel turns a captured distance into a
// phase increment, looks up a sine sample and emits it as PWM (or a square / mute) on one pin.
module fm_dac_ch #(
  parameter int WIDTH       = 13,
  parameter int SINE_WIDTH  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int MAX_DIST    = 2000,
  parameter int BASE_INC    = 2**20,
  parameter int SLOPE       = 2**10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [WIDTH-1:0]      distance,
  input  logic [1:0]            mode,
  input  logic [SINE_WIDTH-1:0] cnt,
  input  logic                  tick,
  output logic                  out
);
  localparam logic [1:0] M_FM = 2'd0, M_TONE = 2'd1, M_MUTE = 2'd2, M_SQUARE = 2'd3;
  localparam logic [PHASE_WIDTH-1:0] BASE = PHASE_WIDTH'(BASE_INC);
  localparam logic [WIDTH-1:0]       DMAX = WIDTH'(MAX_DIST);

  // First quadrant (k = 0..64) of round(127.5 + 127.5*sin(2*pi*k/256)).
  localparam logic [7:0] QTAB [0:64] = '{
    8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
    8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
    8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
    8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
    8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
    8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
    8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255,
    8'd255
  };

  // Full 256-point table by quarter-wave symmetry; k=128 is the rounding tie (127.5 -> 128).
  function automatic logic [7:0] sine_lut(input logic [7:0] k);
    logic [6:0] j, q;
    logic [7:0] hi;
    j  = k[6:0];
    q  = (j > 7'd64) ? 7'(8'd128 - {1'b0, j}) : j;
    hi = QTAB[q];
    if (!k[7])         sine_lut = hi;
    else if (j == '0)  sine_lut = 8'd128;
    else               sine_lut = 8'd255 - hi;
  endfunction

  logic [WIDTH-1:0]       d;
  logic [PHASE_WIDTH-1:0] inc, inc_nxt, phase;
  logic [SINE_WIDTH-1:0]  sample, duty;

  // Mute keeps the FM pitch so the phase keeps tracking distance while silent.
  always_comb begin
    inc_nxt = BASE + PHASE_WIDTH'(DMAX - d) * PHASE_WIDTH'(SLOPE);
    if (mode == M_TONE || mode == M_SQUARE) inc_nxt = BASE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d      <= DMAX;
      inc    <= BASE;
      phase  <= '0;
      sample <= '0;
      duty   <= '0;
      out    <= 1'b0;
    end else begin
      if (load) d <= (distance > DMAX) ? DMAX : distance;
      inc <= inc_nxt;
      if (enable) phase <= phase + inc;
      // ROM is the 256-point table; address is the top 8 phase bits (== SINE_WIDTH at default).
      sample <= SINE_WIDTH'(sine_lut(phase[PHASE_WIDTH-1 -: 8]));
      // Clearing duty while muted makes an un-mute wait for a fresh latch at the counter wrap.
      if (mode == M_MUTE) duty <= '0;
      else if (tick)      duty <= sample;
      if (!enable) out <= 1'b0;
      else begin
        case (mode)
          M_FM, M_TONE: out <= (cnt < duty);
          M_SQUARE:     out <= phase[PHASE_WIDTH-1];
          default:      out <= 1'b0;
        endcase
      end
    end
  end
endmodule

module fm_dac_multi #(
  parameter int WIDTH       = 13,
  parameter int SINE_WIDTH  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int MAX_DIST    = 2000,
  parameter int NUM_CH      = 2,
  parameter int BASE_INC    = 2**20,
  parameter int SLOPE       = 2**10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] distance,
  input  logic [NUM_CH*2-1:0]     mode,
  output logic [NUM_CH-1:0]       sine_pwm_out,
  output logic                    pwm_tick
);
  logic [SINE_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign pwm_tick = enable && !reset && (cnt == '0);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fm_dac_ch #(
      .WIDTH(WIDTH), .SINE_WIDTH(SINE_WIDTH), .PHASE_WIDTH(PHASE_WIDTH),
      .MAX_DIST(MAX_DIST), .BASE_INC(BASE_INC), .SLOPE(SLOPE)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .load     (load[c]),
      .distance (distance[c*WIDTH +: WIDTH]),
      .mode     (mode[c*2 +: 2]),
      .cnt      (cnt),
      .tick     (pwm_tick),
      .out      (sine_pwm_out[c])
    );
  end
endmodule

// File: tb/tb_fm_dac_multi.sv
// Directed bench for fm_dac_multi: tuning words, sine-PWM duty, square/mute, enable freeze, reset.
module tb_fm_dac_multi;
  localparam int W = 13;
  localparam logic [31:0] BASE = 32'd1048576;

  logic         clk = 1'b0;
  logic         reset, enable;
  logic [1:0]   load;
  logic [2*W-1:0] distance;
  logic [3:0]   mode;
  logic [1:0]   sine_pwm_out;
  logic         pwm_tick;
  int checks = 0, passes = 0, k = 0;

  fm_dac_multi dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .distance(distance),
    .mode(mode), .sine_pwm_out(sine_pwm_out), .pwm_tick(pwm_tick)
  );

  wire [31:0] ph0  = dut.g_ch[0].u_ch.phase;
  wire [31:0] ph1  = dut.g_ch[1].u_ch.phase;
  wire [31:0] inc0 = dut.g_ch[0].u_ch.inc;
  wire [31:0] inc1 = dut.g_ch[1].u_ch.inc;

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    k += n;
  endtask

  task automatic step_to(input int t);
    if (t > k) step(t - k);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      hi += int'(sine_pwm_out[ch]);
    end
  endtask

  task automatic test_reset;
    reset = 1; enable = 1; load = 2'b11; distance = '0; mode = 4'b0000;
    step(3);
    checks++; if (sine_pwm_out !== 2'b00) $display("FAIL rst_out: got %b want 00", sine_pwm_out); else passes++;
    checks++; if (pwm_tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", pwm_tick); else passes++;
    checks++; if (ph0 !== 32'd0) $display("FAIL rst_phase: got %0d want 0", ph0); else passes++;
    checks++; if (inc0 !== BASE) $display("FAIL rst_inc: got %0d want %0d", inc0, BASE); else passes++;
  endtask

  task automatic test_fm_base;
    int hi;
    reset = 0; load = 2'b01; distance[0 +: W] = 13'd2000; mode = 4'b0000; k = 0;
    #1;
    checks++; if (pwm_tick !== 1'b1) $display("FAIL tick_release: got %b want 1", pwm_tick); else passes++;
    step(1); load = 2'b00;
    step_to(16);
    checks++; if (ph0 !== 32'h0100_0000) $display("FAIL phase_addr1: got %h want 01000000", ph0); else passes++;
    step_to(255);
    checks++; if (pwm_tick !== 1'b0) $display("FAIL tick_255: got %b want 0", pwm_tick); else passes++;
    step_to(256);
    checks++; if (pwm_tick !== 1'b1) $display("FAIL tick_256: got %b want 1", pwm_tick); else passes++;
    step(1); count_high(0, 256, hi);
    checks++; if (hi != 173) $display("FAIL duty_lut15: got %0d want 173", hi); else passes++;
    step_to(1024);
    step(1); count_high(0, 256, hi);
    checks++; if (hi != 255) $display("FAIL duty_lut63: got %0d want 255", hi); else passes++;
    step_to(3072);
    step(1); count_high(0, 256, hi);
    checks++; if (hi != 0) $display("FAIL duty_lut191: got %0d want 0", hi); else passes++;
    step_to(4096);
    checks++; if (ph0 !== 32'd0) $display("FAIL phase_wrap4096: got %h want 0", ph0); else passes++;
  endtask

  task automatic test_fm_distance;
    distance[0 +: W] = 13'd0; load = 2'b01;
    step(1); load = 2'b00;
    checks++; if (inc0 !== BASE) $display("FAIL inc_latency: got %0d want %0d", inc0, BASE); else passes++;
    step(1);
    checks++; if (inc0 !== 32'd3096576) $display("FAIL inc_d0: got %0d want 3096576", inc0); else passes++;
    distance[0 +: W] = 13'd1500; load = 2'b01;
    step(1); load = 2'b00; step(1);
    checks++; if (inc0 !== 32'd1560576) $display("FAIL inc_d1500: got %0d want 1560576", inc0); else passes++;
    distance[0 +: W] = 13'd5000; load = 2'b01;
    step(1); load = 2'b00; step(1);
    checks++; if (inc0 !== BASE) $display("FAIL inc_clamp: got %0d want %0d", inc0, BASE); else passes++;
  endtask

  task automatic test_square_mute;
    int n, hl, ll;
    logic [31:0] p;
    mode[1:0] = 2'd3;
    n = 0; while (sine_pwm_out[0] !== 1'b0 && n < 5000) begin step(1); n++; end
    n = 0; while (sine_pwm_out[0] !== 1'b1 && n < 5000) begin step(1); n++; end
    hl = 0; while (sine_pwm_out[0] === 1'b1 && hl < 5000) begin step(1); hl++; end
    ll = 0; while (sine_pwm_out[0] === 1'b0 && ll < 5000) begin step(1); ll++; end
    checks++; if (hl != 2048) $display("FAIL square_high: got %0d want 2048", hl); else passes++;
    checks++; if (ll != 2048) $display("FAIL square_low: got %0d want 2048", ll); else passes++;
    mode[1:0] = 2'd2; p = ph0;
    step(1);
    checks++; if (sine_pwm_out[0] !== 1'b0) $display("FAIL mute_1cycle: got %b want 0", sine_pwm_out[0]); else passes++;
    step(9);
    checks++; if (ph0 !== p + 32'd10 * BASE) $display("FAIL mute_phase_runs: got %h want %h", ph0, p + 32'd10 * BASE); else passes++;
  endtask

  task automatic test_mute_resume;
    int hi;
    reset = 1; load = 2'b00; mode = 4'b0010;
    step(2);
    reset = 0; k = 0;
    count_high(0, 1000, hi);
    checks++; if (hi != 0) $display("FAIL mute_hold: got %0d highs want 0", hi); else passes++;
    mode = 4'b0000;
    count_high(0, 24, hi);
    checks++; if (pwm_tick !== 1'b1) $display("FAIL resume_tick: got %b want 1", pwm_tick); else passes++;
    step(1); hi += int'(sine_pwm_out[0]);
    checks++; if (hi != 0) $display("FAIL resume_wait: got %0d highs want 0", hi); else passes++;
    step(1);
    checks++; if (sine_pwm_out[0] !== 1'b1) $display("FAIL resume_pwm: got %b want 1", sine_pwm_out[0]); else passes++;
    hi = int'(sine_pwm_out[0]);
    begin
      int more;
      count_high(0, 255, more);
      hi += more;
    end
    checks++; if (hi != 255) $display("FAIL resume_duty: got %0d want 255", hi); else passes++;
  endtask

  task automatic test_two_channels;
    int n;
    reset = 1; mode = 4'b0000; load = 2'b00;
    step(2);
    reset = 0; load = 2'b11; distance = {13'd1000, 13'd2000}; k = 0;
    step(1); load = 2'b00;
    step_to(10);
    checks++; if (ph0 !== 32'd10485760) $display("FAIL ch0_phase10: got %0d want 10485760", ph0); else passes++;
    checks++; if (ph1 !== 32'd18677760) $display("FAIL ch1_phase10: got %0d want 18677760", ph1); else passes++;
    checks++; if (inc0 !== BASE) $display("FAIL ch0_inc: got %0d want %0d", inc0, BASE); else passes++;
    checks++; if (inc1 !== 32'd2072576) $display("FAIL ch1_inc: got %0d want 2072576", inc1); else passes++;
    step_to(256);
    checks++; if (pwm_tick !== 1'b1) $display("FAIL tick_ch: got %b want 1", pwm_tick); else passes++;
    n = 0;
    do begin step(1); n++; end while (pwm_tick !== 1'b1 && n < 600);
    checks++; if (n != 256) $display("FAIL tick_period: got %0d want 256", n); else passes++;
  endtask

  task automatic test_enable_freeze;
    int n, bad;
    step_to(600);
    checks++; if (sine_pwm_out[0] !== 1'b1) $display("FAIL pre_disable_high: got %b want 1", sine_pwm_out[0]); else passes++;
    enable = 0;
    step(1);
    checks++; if (sine_pwm_out !== 2'b00) $display("FAIL disable_out0: got %b want 00", sine_pwm_out); else passes++;
    bad = 0;
    for (int i = 0; i < 99; i++) begin
      step(1);
      if (sine_pwm_out !== 2'b00 || pwm_tick !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL disable_quiet: got %0d active cycles want 0", bad); else passes++;
    checks++; if (ph0 !== 32'd629145600) $display("FAIL phase_frozen: got %0d want 629145600", ph0); else passes++;
    enable = 1;
    step(1);
    checks++; if (sine_pwm_out[0] !== 1'b1) $display("FAIL resume_out: got %b want 1", sine_pwm_out[0]); else passes++;
    n = 1;
    while (pwm_tick !== 1'b1 && n < 400) begin step(1); n++; end
    checks++; if (n != 168) $display("FAIL counter_resumed: got %0d want 168", n); else passes++;
    checks++; if (ph0 !== 32'd805306368) $display("FAIL phase_resumed: got %0d want 805306368", ph0); else passes++;
  endtask

  task automatic test_reset_mid;
    reset = 1; load = 2'b11; distance = '0; mode = 4'b1111;
    step(1);
    checks++; if (sine_pwm_out !== 2'b00) $display("FAIL midrst_out: got %b want 00", sine_pwm_out); else passes++;
    checks++; if (pwm_tick !== 1'b0) $display("FAIL midrst_tick: got %b want 0", pwm_tick); else passes++;
    checks++; if (ph0 !== 32'd0 || ph1 !== 32'd0) $display("FAIL midrst_phase: got %0d/%0d want 0/0", ph0, ph1); else passes++;
    checks++; if (inc1 !== BASE) $display("FAIL midrst_inc: got %0d want %0d", inc1, BASE); else passes++;
    reset = 0; load = 2'b00; mode = 4'b0000;
    #1;
    checks++; if (pwm_tick !== 1'b1) $display("FAIL midrst_cnt0: got %b want 1", pwm_tick); else passes++;
    step(2);
    checks++; if (inc1 !== BASE || inc0 !== BASE) $display("FAIL midrst_dmax: got %0d/%0d want %0d", inc0, inc1, BASE); else passes++;
  endtask

  initial begin
    test_reset();
    test_fm_base();
    test_fm_distance();
    test_square_mute();
    test_mute_resume();
    test_two_channels();
    test_enable_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: timed out after %0d/%0d checks passed", passes, checks);
    $fatal(1, "timeout");
  end
endmodule
